adau1761_i2s_xcvr: RTL



---
 rtl/adau1761_i2s_xcvr.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/adau1761_i2s_xcvr.sv
// I2S master transceiver for the ADAU1761 serial port: BCLK/LRCLK generation,
// left/right DAC serialization from a one-deep holding register, ADC capture.
module adau1761_i2s_xcvr #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  rx_valid,
  output logic                  underrun,
  input  logic                  clear_underrun,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata_out,
  input  logic                  sdata_in
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] B_LAST   = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] L_END    = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] R_START  = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] R_END    = BIT_W'(SLOT_WIDTH + DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LR_START = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] LR_END   = BIT_W'(2 * SLOT_WIDTH - 2);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdo_q, sdo_d;
  logic [BIT_W-1:0]      b_q, b_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [DATA_WIDTH-1:0] rsh_l_q, rsh_l_d, rsh_r_q, rsh_r_d;
  logic [DATA_WIDTH-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;

  logic             tc, fall, rise, frame_load, xfer;
  logic [BIT_W-1:0] b_nxt;

  assign tc         = (div_q == DIV_LAST);
  assign fall       = enable & tc & bclk_q;
  assign rise       = enable & tc & ~bclk_q;
  assign b_nxt      = (b_q == B_LAST) ? '0 : b_q + 1'b1;
  assign frame_load = fall & (b_nxt == '0);
  assign xfer       = tx_valid & tx_ready_q;

  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdo_d      = sdo_q;
    b_d        = b_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    rsh_l_d    = rsh_l_q;
    rsh_r_d    = rsh_r_q;
    rx_l_d     = rx_l_q;
    rx_r_d     = rx_r_q;
    rx_valid_d = 1'b0;
    if (!enable) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdo_d   = 1'b0;
      b_d     = B_LAST;
      sh_l_d  = '0;
      sh_r_d  = '0;
      rsh_l_d = '0;
      rsh_r_d = '0;
    end else begin
      div_d = tc ? '0 : div_q + 1'b1;
      if (tc) bclk_d = ~bclk_q;
      if (fall) begin
        b_d     = b_nxt;
        lrclk_d = (b_nxt >= LR_START) && (b_nxt <= LR_END);
        sdo_d   = 1'b0;
        // An empty holding register at frame start sends silence.
        if (frame_load) begin
          sdo_d  = ~tx_ready_q & hold_l_q[DATA_WIDTH-1];
          sh_l_d = tx_ready_q ? '0 : {hold_l_q[DATA_WIDTH-2:0], 1'b0};
          sh_r_d = tx_ready_q ? '0 : hold_r_q;
        end else if (b_nxt <= L_END) begin
          sdo_d  = sh_l_q[DATA_WIDTH-1];
          sh_l_d = {sh_l_q[DATA_WIDTH-2:0], 1'b0};
        end else if ((b_nxt >= R_START) && (b_nxt <= R_END)) begin
          sdo_d  = sh_r_q[DATA_WIDTH-1];
          sh_r_d = {sh_r_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      if (rise) begin
        if (b_q <= L_END) begin
          rsh_l_d = {rsh_l_q[DATA_WIDTH-2:0], sdata_in};
        end else if ((b_q >= R_START) && (b_q <= R_END)) begin
          rsh_r_d = {rsh_r_q[DATA_WIDTH-2:0], sdata_in};
          if (b_q == R_END) begin
            rx_l_d     = rsh_l_q;
            rx_r_d     = {rsh_r_q[DATA_WIDTH-2:0], sdata_in};
            rx_valid_d = 1'b1;
          end
        end
      end
    end
  end

  // Holding register: a same-cycle accept overrides the frame-start release.
  always_comb begin
    tx_ready_d = tx_ready_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    underrun_d = underrun_q;
    if (frame_load) tx_ready_d = 1'b1;
    if (xfer) begin
      tx_ready_d = 1'b0;
      hold_l_d   = tx_left;
      hold_r_d   = tx_right;
    end
    if (clear_underrun) underrun_d = 1'b0;
    if (frame_load && tx_ready_q) underrun_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdo_q      <= 1'b0;
      b_q        <= B_LAST;
      tx_ready_q <= 1'b1;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      rsh_l_q    <= '0;
      rsh_r_q    <= '0;
      rx_l_q     <= '0;
      rx_r_q     <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdo_q      <= sdo_d;
      b_q        <= b_d;
      tx_ready_q <= tx_ready_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      rsh_l_q    <= rsh_l_d;
      rsh_r_q    <= rsh_r_d;
      rx_l_q     <= rx_l_d;
      rx_r_q     <= rx_r_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign rx_left   = rx_l_q;
  assign rx_right  = rx_r_q;
  assign rx_valid  = rx_valid_q;
  assign underrun  = underrun_q;
  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata_out = sdo_q;

endmodule
